// File: rtl/iir_pkg.sv
// Shared types and helpers for the IIR filter front end.
`default_nettype none

package iir_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } fifo_state_t;

  // One extra MSB beyond the index acts as the wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iir_sample_fifo_if.sv
// Head-of-FIFO handshake towards the IIR filter input (x_i / valid_i / ready_and_o).
`default_nettype none

interface iir_sample_fifo_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] x_o;
  logic                  valid_o;
  logic                  ready_and_i;

  modport master (output x_o, output valid_o, input ready_and_i);
  modport slave  (input x_o, input valid_o, output ready_and_i);
endinterface

`default_nettype wire

// File: rtl/iir_fifo_mem.sv
// DEPTH x DATA_WIDTH storage, one write port, one asynchronous read port, no reset.
`default_nettype none

module iir_fifo_mem #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/iir_sample_fifo.sv
// Circular sample FIFO with registered first-word-fall-through head and drop accounting.
`default_nettype none

module iir_sample_fifo
  import iir_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  sample_i,
  input  logic                   sample_stb_i,
  input  logic                   flush_i,
  input  logic                   clear_i,
  iir_sample_fifo_if.master      fifo_out,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [CNT_WIDTH-1:0]   drop_cnt_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0]        PTR_ONE = PW'(1);
  localparam logic [AW-1:0]        IDX_ONE = AW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PW-1:0]         wr_ptr, rd_ptr, level;
  logic [AW-1:0]         rd_next_idx;
  logic [DATA_WIDTH-1:0] mem_rdata, head, load_data;
  logic [CNT_WIDTH-1:0]  drop_cnt;
  logic                  overflow;
  logic                  full, pop, push, drop, load;
  fifo_state_t           state, state_nxt;

  assign level       = wr_ptr - rd_ptr;
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign pop         = (state == HOLD) && fifo_out.ready_and_i;
  assign push        = sample_stb_i && (!full || pop) && !flush_i;
  assign drop        = sample_stb_i && full && !pop && !flush_i;
  assign rd_next_idx = rd_ptr[AW-1:0] + IDX_ONE;

  iir_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk_i),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (sample_i),
    .raddr (rd_next_idx),
    .rdata (mem_rdata)
  );

  // The head entry stays in memory at rd_ptr; the register is a copy of it.
  // A sample entering with nothing queued behind the head bypasses memory.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_data = sample_i;
    unique case (state)
      EMPTY: begin
        if (push) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (pop) begin
          if (level > PTR_ONE) begin
            load      = 1'b1;
            load_data = mem_rdata;
          end else if (push) begin
            load      = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= EMPTY;
      head   <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= EMPTY;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (load) head   <= load_data;
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_i)               drop_cnt <= CNT_ONE;
      else if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_ONE;
    end else if (clear_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  assign fifo_out.x_o     = head;
  assign fifo_out.valid_o = (state == HOLD);
  assign level_o          = level;
  assign overflow_o       = overflow;
  assign drop_cnt_o       = drop_cnt;

endmodule

`default_nettype wire
